// File: rtl/inst_dispatch_queue_pkg.sv
// sa_disp_pkg: shared definitions for the instruction dispatch queue and the
// systolic-array control unit.
//   - dispatcher FSM state encoding (2-bit)
//   - default instruction width, opcode/address field bounds, instruction struct
//   - opcode constants (the dispatcher itself never decodes them)
package sa_disp_pkg;

  localparam int unsigned INST_BITS_DEF = 68;
  localparam int unsigned OPC_MSB       = 67;
  localparam int unsigned OPC_LSB       = 64;
  localparam int unsigned ADDR_BITS     = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_WAIT  = 2'd3
  } disp_state_e;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  // Instruction layout: opcode | off-chip address A | off-chip address B
  typedef struct packed {
    opcode_t               opcode;
    logic [ADDR_BITS-1:0]  addr_a;
    logic [ADDR_BITS-1:0]  addr_b;
  } inst_t;

  localparam opcode_t IDLE_INST   = 4'h0;
  localparam opcode_t AXI_TO_UB   = 4'h1;
  localparam opcode_t UB_TO_AXI   = 4'h2;
  localparam opcode_t LOAD_WEIGHT = 4'h3;
  localparam opcode_t MATMUL      = 4'h4;

  function automatic opcode_t get_opcode(input inst_t inst);
    return inst.opcode;
  endfunction

endpackage

// File: rtl/inst_dispatch_queue_if.sv
// inst_dispatch_queue_if: push channel (host -> queue) and issue channel
// (queue <-> systolic array) of the instruction dispatch queue.
//   push_valid/push_inst/push_ready : valid/ready enqueue handshake
//   idle_flag                       : array reports no instruction executing
//   init_inst_pulse/instruction     : 1-cycle issue strobe plus held instruction word
// Modports: master = host/array environment, slave = dispatch queue.
interface inst_dispatch_queue_if #(
  parameter int unsigned INST_BITS = 68
);
  logic                 push_valid;
  logic [INST_BITS-1:0] push_inst;
  logic                 push_ready;
  logic                 idle_flag;
  logic                 init_inst_pulse;
  logic [INST_BITS-1:0] instruction;

  modport master (
    output push_valid, push_inst, idle_flag,
    input  push_ready, init_inst_pulse, instruction
  );

  modport slave (
    input  push_valid, push_inst, idle_flag,
    output push_ready, init_inst_pulse, instruction
  );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO with registered read data and a flush that
// clears the pointers without touching the last read word.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   wr_en/wr_data      enqueue (ignored when full)
//   rd_en              dequeue head into rd_data on the next edge (ignored when empty)
//   flush              drop all stored entries on the next edge
//   rd_data            last dequeued word, held until the next dequeue
//   full/empty/count   occupancy status
module inst_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rd_data = r_rd_data;

  // Flush wins over both operations; full/empty guards make the enables safe.
  assign w_wr = wr_en && !full && !flush;
  assign w_rd = rd_en && !empty && !flush;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_rd) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

endmodule

// File: rtl/inst_dispatch_queue.sv
// inst_dispatch_queue: buffers instructions for the systolic array and issues
// them one at a time, waiting for the array's idle_flag between issues so
// multi-cycle AXI transfers serialise.
// Optional feature: define INST_DISP_TIMEOUT_EN to add an S_WAIT watchdog that
// sets a sticky timeout_err and blocks further dispatch.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   bus (slave)     push handshake, idle_flag, init_inst_pulse, instruction
//   run             level: 1 = dispatch allowed
//   flush           1-cycle: discard queued (not in-flight) entries
//   busy            FSM active or queue non-empty
//   fifo_count      occupied entries
//   done_count      completed instructions (wraps)
//   timeout_err     sticky watchdog flag (0 without INST_DISP_TIMEOUT_EN)
module inst_dispatch_queue
  import sa_disp_pkg::*;
#(
  parameter int unsigned INST_BITS      = INST_BITS_DEF,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ISSUE_GAP      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  inst_dispatch_queue_if.slave   bus,
  input  logic                   run,
  input  logic                   flush,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            done_count,
  output logic                   timeout_err
);

  localparam int unsigned GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_dispatch_queue: DEPTH must be a power of two >= 2");
  end
  if (ISSUE_GAP < 1) begin : g_bad_gap
    $error("inst_dispatch_queue: ISSUE_GAP must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("inst_dispatch_queue: TIMEOUT_CYCLES must be >= 1");
  end

  disp_state_e     r_state;
  logic            r_pulse;
  logic [GW-1:0]   r_gap;
  logic [15:0]     r_done;
  logic            w_full;
  logic            w_empty;
  logic            w_go;
  logic            w_blocked;
  logic            w_push;
  logic [INST_BITS-1:0] w_rd_data;

`ifdef INST_DISP_TIMEOUT_EN
  logic            r_timeout;
  logic [31:0]     r_wdog;
  assign w_blocked = r_timeout;
`else
  assign w_blocked = 1'b0;
`endif

  // Push accepted only when not full and not flushing
  assign bus.push_ready = !w_full && !flush;
  assign w_push         = bus.push_valid && bus.push_ready;

  // Dispatch decision in S_IDLE; pop happens on the same edge
  assign w_go = (r_state == S_IDLE) && run && !w_empty && bus.idle_flag
                && !flush && !w_blocked;

  inst_fifo #(
    .WIDTH (INST_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data (bus.push_inst),
    .rd_en   (w_go),
    .flush   (flush),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  // FIFO read register doubles as the held instruction output
  assign bus.instruction     = w_rd_data;
  assign bus.init_inst_pulse = r_pulse;
  assign done_count          = r_done;
  assign timeout_err         = w_blocked;
  assign busy                = (r_state != S_IDLE) || !w_empty;

  // Dispatcher FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pulse   <= 1'b0;
      r_gap     <= '0;
      r_done    <= '0;
`ifdef INST_DISP_TIMEOUT_EN
      r_timeout <= 1'b0;
      r_wdog    <= '0;
`endif
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_pulse <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_gap   <= GW'(ISSUE_GAP - 1);
          r_state <= S_GAP;
`ifdef INST_DISP_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        // Give the array time to drop idle_flag before it is trusted
        S_GAP: begin
          if (r_gap == '0) r_state <= S_WAIT;
          else             r_gap   <= r_gap - GW'(1);
        end
        S_WAIT: begin
          if (bus.idle_flag) begin
            r_done  <= r_done + 16'd1;
            r_state <= S_IDLE;
          end
`ifdef INST_DISP_TIMEOUT_EN
          else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
